// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM -> WB pipeline register of the MIPS core.
//
// Captures the MEM-stage results under a valid/allowin handshake and extracts
// load data (byte/half/word, sign/zero extend) from the raw read word before
// registering it. It also supports a WB-side stall (hold) and a flush that
// kills both the held entry and the incoming one.
//
// Optional build macro: MEM_WB_TRACE_EN adds the mem_pc_i input and the
// debug_wb_* trace outputs. Without it, those ports and their logic are absent.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_valid_i / wb_allowin_o handshake with MEM
//   wb_stall_i, flush_i        WB hold request, pipeline kill
//   alu_res_i, mem_rdata_i     ALU/address result, raw data-RAM word
//   load_type_i                0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW
//   mem_to_reg_i, cp0_rd_i     writeback source selects
//   cp0_data_i                 CP0 read value
//   rf_we_i, rf_waddr_i        register write request
//   except_i                   exception vector from MEM
//   wb_valid_o, d1_o, d2_o, mem_to_regfile_o, write_from_cp0_o,
//   cp0_data_o, except_o, rf_we_o, rf_waddr_o   WB-stage entry
module mem_wb_reg #(
  parameter int DW  = 32,
  parameter int EXW = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_valid_i,
  output logic           wb_allowin_o,
  input  logic           wb_stall_i,
  input  logic           flush_i,
  input  logic [DW-1:0]  alu_res_i,
  input  logic [DW-1:0]  mem_rdata_i,
  input  logic [2:0]     load_type_i,
  input  logic           mem_to_reg_i,
  input  logic           cp0_rd_i,
  input  logic [DW-1:0]  cp0_data_i,
  input  logic           rf_we_i,
  input  logic [4:0]     rf_waddr_i,
  input  logic [EXW-1:0] except_i,
`ifdef MEM_WB_TRACE_EN
  input  logic [31:0]    mem_pc_i,
  output logic [31:0]    debug_wb_pc,
  output logic [3:0]     debug_wb_rf_wen,
  output logic [4:0]     debug_wb_rf_wnum,
  output logic [31:0]    debug_wb_rf_wdata,
`endif
  output logic           wb_valid_o,
  output logic [DW-1:0]  d1_o,
  output logic [DW-1:0]  d2_o,
  output logic           mem_to_regfile_o,
  output logic           write_from_cp0_o,
  output logic [DW-1:0]  cp0_data_o,
  output logic [EXW-1:0] except_o,
  output logic           rf_we_o,
  output logic [4:0]     rf_waddr_o
);

  logic           valid_q;
  logic [DW-1:0]  d1_q;
  logic [DW-1:0]  d2_q;
  logic           m2r_q;
  logic           cp0_rd_q;
  logic [DW-1:0]  cp0_data_q;
  logic [EXW-1:0] except_q;
  logic           rf_we_q;
  logic [4:0]     waddr_q;
  logic [DW-1:0]  load_data;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;

  assign wb_allowin_o = !valid_q || !wb_stall_i;

  // Lane selection from the low address bits; addr[0] is ignored for halves
  // because a misaligned half already arrives flagged as an exception.
  always_comb begin
    byte_sel  = mem_rdata_i[7:0];
    half_sel  = alu_res_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_data = mem_rdata_i;
    case (alu_res_i[1:0])
      2'd0:    byte_sel = mem_rdata_i[7:0];
      2'd1:    byte_sel = mem_rdata_i[15:8];
      2'd2:    byte_sel = mem_rdata_i[23:16];
      default: byte_sel = mem_rdata_i[31:24];
    endcase
    case (load_type_i)
      3'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    load_data = {24'b0, byte_sel};
      3'd3:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_data = {16'b0, half_sel};
      default: load_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      d1_q       <= '0;
      d2_q       <= '0;
      m2r_q      <= 1'b0;
      cp0_rd_q   <= 1'b0;
      cp0_data_q <= '0;
      except_q   <= '0;
      rf_we_q    <= 1'b0;
      waddr_q    <= '0;
    end else if (flush_i) begin
      // Payload holds; clearing valid alone is enough to block the write.
      valid_q <= 1'b0;
    end else if (wb_allowin_o) begin
      valid_q <= mem_valid_i;
      if (mem_valid_i) begin
        d1_q       <= load_data;
        d2_q       <= alu_res_i;
        m2r_q      <= mem_to_reg_i;
        cp0_rd_q   <= cp0_rd_i;
        cp0_data_q <= cp0_data_i;
        except_q   <= except_i;
        rf_we_q    <= rf_we_i;
        waddr_q    <= rf_waddr_i;
      end
    end
  end

  assign wb_valid_o       = valid_q;
  assign d1_o             = d1_q;
  assign d2_o             = d2_q;
  assign mem_to_regfile_o = m2r_q;
  assign write_from_cp0_o = cp0_rd_q;
  assign cp0_data_o       = cp0_data_q;
  assign except_o         = except_q;
  assign rf_waddr_o       = waddr_q;
  // Excepting entries and bubbles never reach the register file.
  assign rf_we_o          = valid_q && rf_we_q && (except_q == '0);

`ifdef MEM_WB_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else if (!flush_i && wb_allowin_o && mem_valid_i) begin
      pc_q <= mem_pc_i;
    end
  end

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{rf_we_o}};
  assign debug_wb_rf_wnum  = waddr_q;
  assign debug_wb_rf_wdata = cp0_rd_q ? cp0_data_q : (m2r_q ? d1_q : d2_q);
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
module tb_mem_wb_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic        wb_allowin_o;
  logic        wb_stall_i;
  logic        flush_i;
  logic [31:0] alu_res_i;
  logic [31:0] mem_rdata_i;
  logic [2:0]  load_type_i;
  logic        mem_to_reg_i;
  logic        cp0_rd_i;
  logic [31:0] cp0_data_i;
  logic        rf_we_i;
  logic [4:0]  rf_waddr_i;
  logic [6:0]  except_i;
  logic        wb_valid_o;
  logic [31:0] d1_o;
  logic [31:0] d2_o;
  logic        mem_to_regfile_o;
  logic        write_from_cp0_o;
  logic [31:0] cp0_data_o;
  logic [6:0]  except_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
`ifdef MEM_WB_TRACE_EN
  logic [31:0] mem_pc_i;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        m2r;
    logic        wcp0;
    logic [31:0] cp0d;
    logic [6:0]  exc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] pc;
  } ent_t;

  ent_t mdl;
  ent_t exp_q[$];

  mem_wb_reg dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid_i      (mem_valid_i),
    .wb_allowin_o     (wb_allowin_o),
    .wb_stall_i       (wb_stall_i),
    .flush_i          (flush_i),
    .alu_res_i        (alu_res_i),
    .mem_rdata_i      (mem_rdata_i),
    .load_type_i      (load_type_i),
    .mem_to_reg_i     (mem_to_reg_i),
    .cp0_rd_i         (cp0_rd_i),
    .cp0_data_i       (cp0_data_i),
    .rf_we_i          (rf_we_i),
    .rf_waddr_i       (rf_waddr_i),
    .except_i         (except_i),
`ifdef MEM_WB_TRACE_EN
    .mem_pc_i         (mem_pc_i),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
`endif
    .wb_valid_o       (wb_valid_o),
    .d1_o             (d1_o),
    .d2_o             (d2_o),
    .mem_to_regfile_o (mem_to_regfile_o),
    .write_from_cp0_o (write_from_cp0_o),
    .cp0_data_o       (cp0_data_o),
    .except_o         (except_o),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o)
  );

  always #5 clk = ~clk;

  // Reference extraction written as shift-and-mask.
  function automatic logic [31:0] ext(logic [31:0] rd, logic [31:0] ad, logic [2:0] lt);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = rd >> {ad[1:0], 3'b000};
    sh = rd >> {ad[1], 4'b0000};
    case (lt)
      3'd1:    return {{24{sb[7]}}, sb[7:0]};
      3'd2:    return {24'h0, sb[7:0]};
      3'd3:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model with the currently driven inputs, push the expectation,
  // clock the DUT, then pop and compare the whole entry.
  task automatic step();
    ent_t e;
    e = mdl;
    if (rst) begin
      e = '{default: '0};
    end else if (flush_i) begin
      e.valid = 1'b0;
    end else if (!mdl.valid || !wb_stall_i) begin
      e.valid = mem_valid_i;
      if (mem_valid_i) begin
        e.d1    = ext(mem_rdata_i, alu_res_i, load_type_i);
        e.d2    = alu_res_i;
        e.m2r   = mem_to_reg_i;
        e.wcp0  = cp0_rd_i;
        e.cp0d  = cp0_data_i;
        e.exc   = except_i;
        e.we    = rf_we_i;
        e.waddr = rf_waddr_i;
`ifdef MEM_WB_TRACE_EN
        e.pc    = mem_pc_i;
`endif
      end
    end
    exp_q.push_back(e);
    mdl = e;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("wb_valid", 32'(wb_valid_o), 32'(e.valid));
    chk("d1", d1_o, e.d1);
    chk("d2", d2_o, e.d2);
    chk("mem_to_regfile", 32'(mem_to_regfile_o), 32'(e.m2r));
    chk("write_from_cp0", 32'(write_from_cp0_o), 32'(e.wcp0));
    chk("cp0_data", cp0_data_o, e.cp0d);
    chk("except", 32'(except_o), 32'(e.exc));
    chk("rf_waddr", 32'(rf_waddr_o), 32'(e.waddr));
    chk("rf_we", 32'(rf_we_o), 32'(e.valid && e.we && (e.exc == 7'd0)));
    chk("allowin", 32'(wb_allowin_o), 32'(!e.valid || !wb_stall_i));
`ifdef MEM_WB_TRACE_EN
    chk("debug_pc", debug_wb_pc, e.pc);
    chk("debug_wnum", 32'(debug_wb_rf_wnum), 32'(e.waddr));
`endif
  endtask

  task automatic load(logic [2:0] lt, logic [31:0] addr);
    mem_valid_i  = 1'b1;
    mem_rdata_i  = 32'h80FF7F01;
    alu_res_i    = addr;
    load_type_i  = lt;
    mem_to_reg_i = 1'b1;
    rf_we_i      = 1'b1;
    rf_waddr_i   = 5'd3;
    step();
  endtask

  initial begin
    mdl          = '{default: '0};
    rst          = 1'b1;
    mem_valid_i  = 1'b1;
    wb_stall_i   = 1'b0;
    flush_i      = 1'b0;
    alu_res_i    = 32'hAAAA5555;
    mem_rdata_i  = 32'h12345678;
    load_type_i  = 3'd5;
    mem_to_reg_i = 1'b1;
    cp0_rd_i     = 1'b1;
    cp0_data_i   = 32'hCAFEF00D;
    rf_we_i      = 1'b1;
    rf_waddr_i   = 5'd31;
    except_i     = 7'b0000001;
`ifdef MEM_WB_TRACE_EN
    mem_pc_i     = 32'hBFC00000;
`endif

    // Reset held two cycles with a valid instruction presented.
    step();
    step();
    chk("reset_valid", 32'(wb_valid_o), 32'd0);
    chk("reset_d1", d1_o, 32'd0);
    chk("reset_except", 32'(except_o), 32'd0);
    rst      = 1'b0;
    cp0_rd_i = 1'b0;
    except_i = 7'd0;

    // Load extraction.
    load(3'd1, 32'h10000003);
    chk("lb_sign", d1_o, 32'hFFFFFF80);
    load(3'd2, 32'h10000003);
    chk("lbu_zero", d1_o, 32'h00000080);
    load(3'd3, 32'h10000000);
    chk("lh_low", d1_o, 32'h00007F01);
    load(3'd4, 32'h10000002);
    chk("lhu_high", d1_o, 32'h000080FF);
    load(3'd3, 32'h10000003);
    chk("lh_high_addr0_ignored", d1_o, 32'hFFFF80FF);
    for (int a = 0; a < 3; a++) load(3'd1, 32'(a));
    load(3'd5, 32'h10000000);
    chk("lw", d1_o, 32'h80FF7F01);
    load(3'd7, 32'h10000001);
    chk("type7_raw", d1_o, 32'h80FF7F01);

    // Stall holds the entry.
    mem_to_reg_i = 1'b0;
    load_type_i  = 3'd0;
    alu_res_i    = 32'h1234;
    step();
    chk("pre_stall_d2", d2_o, 32'h1234);
    wb_stall_i = 1'b1;
    alu_res_i  = 32'h5678;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_allowin", 32'(wb_allowin_o), 32'd0);
      chk("stall_d2", d2_o, 32'h1234);
    end
    wb_stall_i = 1'b0;
    step();
    chk("release_d2", d2_o, 32'h5678);

    // Flush with an incoming valid write.
    flush_i   = 1'b1;
    alu_res_i = 32'h9999;
    step();
    chk("flush_valid", 32'(wb_valid_o), 32'd0);
    chk("flush_we", 32'(rf_we_o), 32'd0);
    flush_i = 1'b0;

    // Flush during a stall.
    step();
    wb_stall_i = 1'b1;
    flush_i    = 1'b1;
    step();
    chk("stall_flush_valid", 32'(wb_valid_o), 32'd0);
    flush_i    = 1'b0;
    wb_stall_i = 1'b0;

    // Exception gates the write.
    except_i  = 7'b0000100;
    alu_res_i = 32'h4444;
    step();
    chk("exc_valid", 32'(wb_valid_o), 32'd1);
    chk("exc_vec", 32'(except_o), 32'h4);
    chk("exc_we", 32'(rf_we_o), 32'd0);
    except_i = 7'b0110000;
    step();
    except_i = 7'd0;

    // MFC0.
    cp0_rd_i   = 1'b1;
    cp0_data_i = 32'hDEADBEEF;
    rf_waddr_i = 5'd8;
`ifdef MEM_WB_TRACE_EN
    mem_pc_i   = 32'hBFC00100;
`endif
    step();
    chk("mfc0_sel", 32'(write_from_cp0_o), 32'd1);
    chk("mfc0_data", cp0_data_o, 32'hDEADBEEF);
    chk("mfc0_waddr", 32'(rf_waddr_o), 32'd8);
    chk("mfc0_we", 32'(rf_we_o), 32'd1);
`ifdef MEM_WB_TRACE_EN
    chk("trace_wdata", debug_wb_rf_wdata, 32'hDEADBEEF);
    chk("trace_wen", 32'(debug_wb_rf_wen), 32'hF);
`endif
    cp0_rd_i = 1'b0;

    // Bubble: valid drops, payload holds.
    mem_valid_i = 1'b0;
    alu_res_i   = 32'h7777;
    step();
    chk("bubble_we", 32'(rf_we_o), 32'd0);
    chk("bubble_hold_d2", d2_o, 32'h4444 ^ 32'h4444 ^ 32'h0000_4444);

    // Reset in the middle of a stall.
    mem_valid_i = 1'b1;
    step();
    wb_stall_i = 1'b1;
    rst        = 1'b1;
    step();
    chk("stall_reset_d2", d2_o, 32'd0);
    rst        = 1'b0;
    wb_stall_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
- Pipeline register between the MEM stage and the WB stage of the MIPS core.
- Captures MEM results under a valid/allowin handshake and extracts load data (byte/half/word, sign/zero extend) from the raw 32-bit memory read word.
- Drives the WB stage inputs: d1, d2, mem_to_regfile, i_except, i_write_from_cp0 and cp0_data.
- Supports WB-side stall and pipeline flush.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- EXW, 7, width of the one-hot exception vector.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_valid_i  in  1  MEM holds a valid instruction.
- wb_allowin_o  out  1  this register can accept from MEM this cycle.
- wb_stall_i  in  1  WB cannot retire; hold the current entry.
- flush_i  in  1  exception/eret flush; kill the current entry and the incoming one.
- alu_res_i  in  32  ALU/address result.
- mem_rdata_i  in  32  raw data-RAM read word, valid in the MEM cycle.
- load_type_i  in  3  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW; 6-7 treated as none.
- mem_to_reg_i  in  1  select load data for writeback.
- cp0_rd_i  in  1  instruction is MFC0.
- cp0_data_i  in  32  CP0 read value.
- rf_we_i  in  1  register write enable.
- rf_waddr_i  in  5  destination register.
- except_i  in  7  one-hot exception vector from MEM.
- wb_valid_o  out  1  WB entry valid.
- d1_o  out  32  extended load data.
- d2_o  out  32  registered alu_res.
- mem_to_regfile_o  out  1  registered mem_to_reg.
- write_from_cp0_o  out  1  registered cp0_rd.
- cp0_data_o  out  32  registered cp0_data.
- except_o  out  7  registered except vector.
- rf_we_o  out  1  final write enable.
- rf_waddr_o  out  5  registered destination register.

Behaviour:
- Reset: when rst=1 at a rising edge, every register is cleared.
  - wb_valid_o=0 and rf_we_o=0.
  - All data outputs are 0, including except_o=7'b0.
  - Reset mid-stall or mid-flush behaves identically.
- Handshake: wb_allowin_o = !wb_valid_o || !wb_stall_i (combinational).
- Edge priority: rst > flush_i > capture > hold.
  - flush_i=1: wb_valid_o<=0. Payload may update or hold, but rf_we_o must be 0.
  - else if wb_allowin_o=1: wb_valid_o<=mem_valid_i. Payload is captured only when mem_valid_i=1; otherwise the payload holds.
  - else (stalled, valid entry): the whole entry holds unchanged for any number of cycles.
- Latency: one cycle; an input captured at edge N is visible after edge N.
- Load extraction, computed combinationally from mem_rdata_i and alu_res_i[1:0], then registered into d1_o:
  - LB/LBU: byte = rdata[8*a+7 : 8*a] with a=addr[1:0]; sign- or zero-extended to 32 bits.
  - LH/LHU: half = addr[1] ? rdata[31:16] : rdata[15:0]; sign- or zero-extended. addr[0] is ignored, because misalignment is already flagged as ADEL in except_i.
  - LW, none, 6-7: d1 = rdata unchanged.
- Write enable: rf_we_o = wb_valid_o && rf_we_q && (except_o == 0). It is combinational from the registered values, so an excepting or bubble instruction never writes the regfile.
- except_o is passed through unmodified, including non-one-hot values. Encoding into an excode is WB's job.
- Simultaneous flush_i and mem_valid_i=1: the incoming entry is dropped and wb_valid_o=0.
- Simultaneous stall and flush: flush wins.

Optional Feature:
- Macro: MEM_WB_TRACE_EN.
- Defined:
  - Adds input mem_pc_i[31:0] and outputs debug_wb_pc[31:0], debug_wb_rf_wen[3:0], debug_wb_rf_wnum[4:0] and debug_wb_rf_wdata[31:0] for the trace comparator.
  - debug_wb_pc is the registered PC, captured under the same capture/hold rules as the payload.
  - debug_wb_rf_wen = {4{rf_we_o}}.
  - debug_wb_rf_wnum = rf_waddr_o.
  - debug_wb_rf_wdata = write_from_cp0_o ? cp0_data_o : (mem_to_regfile_o ? d1_o : d2_o).
  - All debug outputs reset to 0.
- Undefined: none of these ports exist, and there is no logic change otherwise.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_valid_i=1 -> wb_valid_o=0, rf_we_o=0, d1_o=d2_o=0, except_o=0.
- LB sign extension: mem_rdata_i=32'h80FF7F01, alu_res_i=32'h1000_0003, load_type_i=1, mem_valid_i=1 -> next cycle d1_o=32'hFFFFFF80.
  - Same stimulus with LBU -> 32'h00000080.
  - LH at addr[1]=0 -> 32'h00007F01.
  - LHU at addr[1]=1 -> 32'h000080FF.
- Stall: valid entry with alu_res=32'h1234, wb_stall_i=1 for 3 cycles while MEM presents alu_res=32'h5678 -> wb_allowin_o=0 and d2_o stays 32'h1234.
  - Release stall -> next cycle d2_o=32'h5678.
- Flush: flush_i=1 together with mem_valid_i=1 and rf_we_i=1 -> next cycle wb_valid_o=0, rf_we_o=0.
  - Flush during a stall -> wb_valid_o=0 after the edge.
- Exception gating: except_i=7'b0000100 with rf_we_i=1 -> wb_valid_o=1, except_o=7'b0000100, rf_we_o=0.
- MFC0: cp0_rd_i=1, cp0_data_i=32'hDEADBEEF, rf_waddr_i=5'd8 -> write_from_cp0_o=1, cp0_data_o=32'hDEADBEEF, rf_waddr_o=8.
  - With MEM_WB_TRACE_EN defined: debug_wb_rf_wdata=32'hDEADBEEF and debug_wb_rf_wen=4'hF.
